// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared defaults and palette mapping for the Mandelbrot pixel path
package mandelbrot_pkg;

  localparam int CTRWIDTH_DEFAULT = 4;
  localparam int WIDTH_DEFAULT    = 640;
  localparam int HEIGHT_DEFAULT   = 480;

  // Maps the low four count bits to {R[1:0], G[1:0], B[1:0]}; points inside the set are black.
  function automatic logic [5:0] palette_rgb(input logic [3:0] ctr, input logic in_set);
    logic [5:0] rgb;
    if (in_set) begin
      rgb = 6'b000000;
    end else begin
      rgb = {ctr[3:2], ctr[1:0], ~ctr[3:2]};
    end
    return rgb;
  endfunction

endpackage

// File: rtl/mandelbrot_sync_fifo.sv
// rtl/mandelbrot_sync_fifo.sv - synchronous FIFO without fall-through, drop-on-full write side
module mandelbrot_sync_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_tvalid_i,
  input  logic [DW-1:0]              wr_tdata_i,
  input  logic                       rd_tready_i,
  output logic                       rd_tvalid_o,
  output logic [DW-1:0]              rd_tdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full;
  logic          rd_fire;
  logic          wr_fire;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign rd_fire = rd_tready_i && (level_q != '0);
  // A full buffer still accepts a write when a read frees a slot in the same cycle.
  assign wr_fire = wr_tvalid_i && (!full || rd_fire);
  assign drop_o  = wr_tvalid_i && full && !rd_fire;

  assign rd_tvalid_o = (level_q != '0);
  assign rd_tdata_o  = mem_q[rd_ptr_q];
  assign level_o     = level_q;

  // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all buffered entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      mem_q[wr_ptr_q] <= wr_tdata_i;
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// rtl/mandelbrot_pixel_sink.sv - buffers iteration counts and tags them with raster coordinates; palette output under MANDELBROT_PIXEL_SINK_PALETTE_EN
module mandelbrot_pixel_sink
  import mandelbrot_pkg::*;
#(
  parameter int CTRWIDTH = CTRWIDTH_DEFAULT,
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int HEIGHT   = HEIGHT_DEFAULT,
  parameter int DEPTH    = 8,
  localparam int XW      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CTRWIDTH-1:0]       in_ctr,
  input  logic                      in_valid,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CTRWIDTH-1:0]       out_ctr,
  output logic [XW-1:0]             out_x,
  output logic [YW-1:0]             out_y,
  output logic                      out_sof,
  output logic                      out_eol,
`ifdef MANDELBROT_PIXEL_SINK_PALETTE_EN
  output logic [5:0]                out_rgb,
`endif
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  logic          rd_fire;
  logic          drop;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;
  logic          y_last;
  logic          overflow_q;

  mandelbrot_sync_fifo #(
    .DW    (CTRWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_tvalid_i (in_valid),
    .wr_tdata_i  (in_ctr),
    .rd_tready_i (out_ready),
    .rd_tvalid_o (out_valid),
    .rd_tdata_o  (out_ctr),
    .level_o     (level),
    .drop_o      (drop)
  );

  assign rd_fire = out_valid && out_ready;
  assign x_last  = (x_q == XW'(WIDTH - 1));
  assign y_last  = (y_q == YW'(HEIGHT - 1));

  // Coordinates advance per consumed pixel only, so dropped strobes never skew the raster.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (rd_fire) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Raster position registers; reset restarts the frame at pixel (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Sticky overflow: set by any dropped strobe, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign out_x    = x_q;
  assign out_y    = y_q;
  assign out_sof  = (x_q == '0) && (y_q == '0);
  assign out_eol  = x_last;
  assign overflow = overflow_q;

`ifdef MANDELBROT_PIXEL_SINK_PALETTE_EN
  // Palette uses the low four count bits, so CTRWIDTH must be at least 4 with this option.
  logic in_set;
  assign in_set  = (out_ctr == {CTRWIDTH{1'b1}});
  assign out_rgb = out_valid ? palette_rgb(out_ctr[3:0], in_set) : 6'b000000;
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// tb/tb_mandelbrot_pixel_sink.sv - directed self-checking bench for mandelbrot_pixel_sink
module tb_mandelbrot_pixel_sink;

  logic       clk;
  logic       reset;
  logic [3:0] in_ctr;
  logic       in_valid;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_ctr;
  logic [1:0] out_x;
  logic [0:0] out_y;
  logic       out_sof;
  logic       out_eol;
`ifdef MANDELBROT_PIXEL_SINK_PALETTE_EN
  logic [5:0] out_rgb;
`endif
  logic [3:0] level;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

  mandelbrot_pixel_sink #(
    .CTRWIDTH (4),
    .WIDTH    (4),
    .HEIGHT   (2),
    .DEPTH    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ctr    (in_ctr),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ctr   (out_ctr),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
`ifdef MANDELBROT_PIXEL_SINK_PALETTE_EN
    .out_rgb   (out_rgb),
`endif
    .level     (level),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] exp_d   [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};
  logic [1:0] exp_x   [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       exp_y   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       exp_eol [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       exp_sof [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // reset with strobes and reads active: both must be ignored
    reset = 1'b1; in_valid = 1'b1; in_ctr = 4'd9; out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);

    // single write, latency of one cycle
    reset = 1'b0; in_valid = 1'b1; in_ctr = 4'd5; out_ready = 1'b0;
    check("pre_write_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("w1_valid", out_valid, 1);
    check("w1_ctr", out_ctr, 5);
    check("w1_x", out_x, 0);
    check("w1_y", out_y, 0);
    check("w1_sof", out_sof, 1);
    check("w1_eol", out_eol, 0);
    check("w1_level", level, 1);
    tick();
    check("hold_ctr", out_ctr, 5);
    check("hold_level", level, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("r1_valid", out_valid, 0);
    check("r1_level", level, 0);
    check("r1_x", out_x, 1);

    // nine strobes into an eight-deep buffer: ninth dropped
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_ctr   = 4'(i + 1);
      tick();
      if (i == 7) begin
        check("fill8_level", level, 8);
        check("fill8_ovf", overflow, 0);
      end
    end
    in_valid = 1'b0;
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_ctr", out_ctr, i + 1);
      tick();
    end
    out_ready = 1'b0;
    check("drain_level", level, 0);
    check("drain_valid", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // full buffer with simultaneous write and read, then raster walk over 9 reads
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_ctr   = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    check("full_level", level, 8);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check("seq_ctr", out_ctr, exp_d[k]);
      check("seq_x", out_x, exp_x[k]);
      check("seq_y", out_y, exp_y[k]);
      check("seq_eol", out_eol, exp_eol[k]);
      check("seq_sof", out_sof, exp_sof[k]);
      in_valid = (k == 0);
      in_ctr   = 4'd12;
      tick();
      in_valid = 1'b0;
      if (k == 0) begin
        check("rw_level", level, 8);
        check("rw_ovf", overflow, 0);
      end
    end
    out_ready = 1'b0;
    check("seq_end_level", level, 0);
    check("seq_end_x", out_x, 1);

    // mid-stream reset with level 3 at x=2
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_ctr   = 4'(i + 1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctr    = 4'd3;
    tick();
    in_valid = 1'b0;
    check("mid_level", level, 3);
    check("mid_x", out_x, 2);
    check("mid_y", out_y, 1);
    check("mid_ctr", out_ctr, 7);
    check("mid_ovf", overflow, 1);
    reset = 1'b1; in_valid = 1'b1; in_ctr = 4'd9;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_level", level, 0);
    check("mrst_x", out_x, 0);
    check("mrst_y", out_y, 0);
    check("mrst_ovf", overflow, 0);
    in_valid = 1'b1; in_ctr = 4'd4;
    tick();
    in_valid = 1'b0;
    check("restart_ctr", out_ctr, 4);
    check("restart_level", level, 1);
    check("restart_sof", out_sof, 1);

`ifdef MANDELBROT_PIXEL_SINK_PALETTE_EN
    pulse_reset();
    check("rgb_idle", out_rgb, 0);
    in_valid = 1'b1; in_ctr = 4'd15;
    tick();
    in_valid = 1'b0;
    check("rgb_inset_valid", out_valid, 1);
    check("rgb_inset", out_rgb, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctr = 4'd6;
    tick();
    in_valid = 1'b0;
    check("rgb_six", out_rgb, 6'b011010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rgb_empty", out_rgb, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
